// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the proc2 memory-side responder.
package proc_mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LED_W  = 10;

  // Region selectors taken from ADDR[15:12]
  localparam logic [3:0] ROM_BASE = 4'h0;
  localparam logic [3:0] RAM_BASE = 4'h1;
  localparam logic [3:0] LED_BASE = 4'h2;
  localparam logic [3:0] SW_BASE  = 4'h3;
  localparam logic [3:0] CNT_BASE = 4'h4;

  // Counter register addresses (counter build only)
  localparam logic [ADDR_W-1:0] CNT_WR_ADDR  = 16'h4000;
  localparam logic [ADDR_W-1:0] CNT_REJ_ADDR = 16'h4001;

  typedef enum logic [2:0] {
    REG_ROM,
    REG_RAM,
    REG_LED,
    REG_SW,
    REG_CNT,
    REG_NONE
  } region_e;

  // Map the top address nibble to a target; region 4 exists only with counters
  function automatic region_e decode_region(input logic [3:0] nib, input logic cnt_en);
    case (nib)
      ROM_BASE: decode_region = REG_ROM;
      RAM_BASE: decode_region = REG_RAM;
      LED_BASE: decode_region = REG_LED;
      SW_BASE:  decode_region = REG_SW;
      CNT_BASE: decode_region = cnt_en ? REG_CNT : REG_NONE;
      default:  decode_region = REG_NONE;
    endcase
  endfunction

  // Built-in contents of inst_mem.mif; unlisted words are zero
  function automatic logic [DATA_W-1:0] rom_image(input logic [31:0] idx);
    case (idx)
      32'd0:   rom_image = 16'h3002;
      32'd1:   rom_image = 16'h1005;
      32'd2:   rom_image = 16'h5004;
      32'd3:   rom_image = 16'hA001;
      32'd4:   rom_image = 16'h2003;
      32'd5:   rom_image = 16'h7E10;
      default: rom_image = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/proc_mem_responder_if.sv
// Processor-side bus: word address, write data, write strobe and read data.
interface proc_mem_responder_if;

  logic [proc_mem_pkg::ADDR_W-1:0] ADDR;
  logic [proc_mem_pkg::DATA_W-1:0] DOUT;
  logic                            W;
  logic [proc_mem_pkg::DATA_W-1:0] DIN;

  modport master (output ADDR, output DOUT, output W, input DIN);
  modport slave  (input ADDR, input DOUT, input W, output DIN);

endinterface

// File: rtl/proc_mem_responder_sync_ram.sv
// sync_ram: single-port, write-first memory with a registered read port.
// With IS_ROM set the contents come from the built-in image and writes are dropped.
module sync_ram
  import proc_mem_pkg::*;
#(
  parameter int unsigned DEPTH    = 128,
  parameter bit          IS_ROM   = 1'b0,
  parameter bit          IMAGE_EN = 1'b0,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Read data for this access; a same-address write is returned directly
  always_comb begin
    rdata_d = mem_q[addr];
    if (IS_ROM) begin
      rdata_d = IMAGE_EN ? rom_image(32'(addr)) : '0;
    end else if (we) begin
      rdata_d = wdata;
    end
  end

  // Storage and read register; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we && !IS_ROM) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/proc_mem_responder.sv
// proc_mem_responder: decodes proc2 bus accesses into ROM, RAM, LED register and
// synchronised switches, returning read data one cycle after the address.
// Optional access counters in region 4 are built when PROC_MEM_ACCESS_COUNT_EN is defined.
module proc_mem_responder
  import proc_mem_pkg::*;
#(
  parameter int unsigned ROM_WORDS = 128,
  parameter int unsigned RAM_WORDS = 128,
  parameter              ROM_INIT  = "inst_mem.mif"
) (
  input  logic                 Clock,
  input  logic                 Reset,
  proc_mem_responder_if.slave  bus,
  input  logic [LED_W-1:0]     SW,
  output logic [LED_W-1:0]     LEDR
);

  localparam int unsigned ROM_AW = $clog2(ROM_WORDS);
  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
  localparam bit ROM_IMAGE_EN = (ROM_INIT == "inst_mem.mif");
`ifdef PROC_MEM_ACCESS_COUNT_EN
  localparam logic CNT_EN = 1'b1;
`else
  localparam logic CNT_EN = 1'b0;
`endif

  region_e           region_c, region_d, region_q;
  logic              wr_en_c, ram_we_c, led_we_c;
  logic [LED_W-1:0]  led_d, led_q;
  logic [LED_W-1:0]  sw_meta_d, sw_meta_q, sw_sync_d, sw_sync_q;
  logic [DATA_W-1:0] io_rdata_d, io_rdata_q;
  logic [DATA_W-1:0] cnt_rd_c;
  logic [DATA_W-1:0] rom_rdata, ram_rdata;

  // Address decode and write qualification; nothing is written while in reset
  always_comb begin
    region_c = decode_region(bus.ADDR[ADDR_W-1:ADDR_W-4], CNT_EN);
    wr_en_c  = bus.W && !Reset;
    ram_we_c = wr_en_c && (region_c == REG_RAM);
    led_we_c = wr_en_c && (region_c == REG_LED);
    region_d = Reset ? REG_NONE : region_c;
  end

  sync_ram #(
    .DEPTH    (ROM_WORDS),
    .IS_ROM   (1'b1),
    .IMAGE_EN (ROM_IMAGE_EN)
  ) u_rom (
    .clk   (Clock),
    .we    (1'b0),
    .addr  (bus.ADDR[ROM_AW-1:0]),
    .wdata (bus.DOUT),
    .rdata (rom_rdata)
  );

  sync_ram #(
    .DEPTH    (RAM_WORDS),
    .IS_ROM   (1'b0),
    .IMAGE_EN (1'b0)
  ) u_ram (
    .clk   (Clock),
    .we    (ram_we_c),
    .addr  (bus.ADDR[RAM_AW-1:0]),
    .wdata (bus.DOUT),
    .rdata (ram_rdata)
  );

  // LED register and two-flop switch synchroniser
  always_comb begin
    led_d     = led_q;
    sw_meta_d = SW;
    sw_sync_d = sw_meta_q;
    if (Reset) begin
      led_d     = '0;
      sw_meta_d = '0;
      sw_sync_d = '0;
    end else if (led_we_c) begin
      led_d = bus.DOUT[LED_W-1:0];
    end
  end

`ifdef PROC_MEM_ACCESS_COUNT_EN
  logic [DATA_W-1:0] wr_count_d, wr_count_q, rej_count_d, rej_count_q;
  logic              clr_c, rej_c;

  // Write/reject counters; a clear write beats any increment in the same cycle
  always_comb begin
    clr_c       = wr_en_c && (bus.ADDR == CNT_WR_ADDR);
    rej_c       = wr_en_c && !ram_we_c && !led_we_c && !clr_c;
    wr_count_d  = wr_count_q;
    rej_count_d = rej_count_q;
    if (Reset || clr_c) begin
      wr_count_d  = '0;
      rej_count_d = '0;
    end else begin
      if (ram_we_c || led_we_c) wr_count_d = wr_count_q + DATA_W'(1);
      if (rej_c) rej_count_d = rej_count_q + DATA_W'(1);
    end
    cnt_rd_c = '0;
    if (bus.ADDR == CNT_WR_ADDR) begin
      cnt_rd_c = wr_count_d;
    end else if (bus.ADDR == CNT_REJ_ADDR) begin
      cnt_rd_c = rej_count_d;
    end
  end

  // Counter state
  always_ff @(posedge Clock) begin
    wr_count_q  <= wr_count_d;
    rej_count_q <= rej_count_d;
  end
`else
  logic unused_addr_c;
  assign unused_addr_c = ^bus.ADDR;
  assign cnt_rd_c      = '0;
`endif

  // Read data for the register-style targets, captured alongside the region
  always_comb begin
    io_rdata_d = '0;
    if (!Reset) begin
      case (region_c)
        REG_LED: io_rdata_d = {{(DATA_W-LED_W){1'b0}}, led_d};
        REG_SW:  io_rdata_d = {{(DATA_W-LED_W){1'b0}}, sw_sync_q};
        REG_CNT: io_rdata_d = cnt_rd_c;
        default: io_rdata_d = '0;
      endcase
    end
  end

  // Responder state registers
  always_ff @(posedge Clock) begin
    region_q   <= region_d;
    led_q      <= led_d;
    sw_meta_q  <= sw_meta_d;
    sw_sync_q  <= sw_sync_d;
    io_rdata_q <= io_rdata_d;
  end

  // Return path selects between registered sources only
  always_comb begin
    case (region_q)
      REG_ROM: bus.DIN = rom_rdata;
      REG_RAM: bus.DIN = ram_rdata;
      default: bus.DIN = io_rdata_q;
    endcase
  end

  assign LEDR = led_q;

endmodule

// File: tb/tb_proc_mem_responder.sv
// Self-checking bench for proc_mem_responder: directed scenarios plus random traffic
// checked against a behavioural model of the memory map.
module tb_proc_mem_responder;

`ifdef PROC_MEM_ACCESS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       Clock;
  logic       Reset;
  logic [9:0] SW;
  logic [9:0] LEDR;

  proc_mem_responder_if bus_if ();

  proc_mem_responder #(
    .ROM_WORDS (128),
    .RAM_WORDS (128),
    .ROM_INIT  ("inst_mem.mif")
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_if),
    .SW    (SW),
    .LEDR  (LEDR)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the memory map
  logic [15:0] m_ram   [128];
  bit          m_ram_v [128];
  logic [9:0]  m_led;
  logic [9:0]  m_meta, m_sync;
  logic [15:0] m_wr, m_rej;

  function automatic logic [15:0] img(input int i);
    logic [15:0] t [6] = '{16'h3002, 16'h1005, 16'h5004, 16'hA001, 16'h2003, 16'h7E10};
    return (i < 6) ? t[i] : 16'h0000;
  endfunction

  // One bus cycle: present inputs, advance the model, clock, settle past the edge
  task automatic step(input logic [15:0] addr, input logic [15:0] dout, input logic w,
                      input logic rst, output logic [15:0] exp, output bit known);
    int idx;
    bus_if.ADDR = addr;
    bus_if.DOUT = dout;
    bus_if.W    = w;
    Reset       = rst;
    idx   = int'(addr[6:0]);
    exp   = 16'h0000;
    known = 1'b1;
    if (rst) begin
      m_led = '0; m_meta = '0; m_sync = '0; m_wr = '0; m_rej = '0;
    end else begin
      case (addr[15:12])
        4'h0: begin exp = img(idx); if (w) m_rej++; end
        4'h1: begin
          if (w) begin m_ram[idx] = dout; m_ram_v[idx] = 1'b1; m_wr++; end
          known = m_ram_v[idx];
          exp   = m_ram[idx];
        end
        4'h2: begin if (w) begin m_led = dout[9:0]; m_wr++; end exp = {6'b0, m_led}; end
        4'h3: begin exp = {6'b0, m_sync}; if (w) m_rej++; end
        4'h4: begin
          if (CNT_EN) begin
            if (w && addr == 16'h4000) begin m_wr = '0; m_rej = '0; end
            else if (w) m_rej++;
            exp = (addr == 16'h4000) ? m_wr : (addr == 16'h4001) ? m_rej : 16'h0000;
          end
        end
        default: if (w) m_rej++;
      endcase
      m_sync = m_meta;
      m_meta = SW;
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e; bit k;
    for (int i = 0; i < 3; i++) begin
      step(16'(($urandom_range(0, 3) << 12) | $urandom_range(0, 255)), 16'h0, 1'b0, 1'b1, e, k);
      n_checks++;
      if (bus_if.DIN !== 16'h0000) begin
        n_fail++; $display("FAIL reset_din cycle %0d: got %h want 0000", i, bus_if.DIN);
      end
      n_checks++;
      if (LEDR !== 10'h000) begin
        n_fail++; $display("FAIL reset_ledr: got %h want 000", LEDR);
      end
    end
  endtask

  task automatic test_rom();
    logic [15:0] e; bit k;
    step(16'h0000, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'h3002) begin
      n_fail++; $display("FAIL rom_word0: got %h want 3002", bus_if.DIN);
    end
    step(16'h0F83, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'hA001) begin
      n_fail++; $display("FAIL rom_wrap: got %h want a001", bus_if.DIN);
    end
    step(16'h0001, 16'h1234, 1'b1, 1'b0, e, k);
    step(16'h0001, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'h1005) begin
      n_fail++; $display("FAIL rom_write_ignored: got %h want 1005", bus_if.DIN);
    end
  endtask

  task automatic test_ram();
    logic [15:0] e; bit k;
    step(16'h1005, 16'hBEEF, 1'b1, 1'b0, e, k);
    step(16'h1005, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'hBEEF) begin
      n_fail++; $display("FAIL ram_read: got %h want beef", bus_if.DIN);
    end
    step(16'h1085, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'hBEEF) begin
      n_fail++; $display("FAIL ram_wrap: got %h want beef", bus_if.DIN);
    end
    step(16'h1010, 16'h0000, 1'b1, 1'b0, e, k);
    step(16'h1010, 16'hBEEF, 1'b1, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'hBEEF) begin
      n_fail++; $display("FAIL ram_write_first: got %h want beef", bus_if.DIN);
    end
  endtask

  task automatic test_led();
    logic [15:0] e; bit k;
    step(16'h2000, 16'h03FF, 1'b1, 1'b0, e, k);
    n_checks++;
    if (LEDR !== 10'h3FF) begin
      n_fail++; $display("FAIL led_write: got %h want 3ff", LEDR);
    end
    step(16'h2000, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'h03FF) begin
      n_fail++; $display("FAIL led_read: got %h want 03ff", bus_if.DIN);
    end
  endtask

  task automatic test_sw();
    logic [15:0] e; bit k;
    logic [15:0] want [3] = '{16'h0000, 16'h0000, 16'h0155};
    SW = 10'h155;
    for (int i = 0; i < 3; i++) begin
      step(16'h3000, 16'h0, 1'b0, 1'b0, e, k);
      n_checks++;
      if (bus_if.DIN !== want[i] || e !== want[i]) begin
        n_fail++; $display("FAIL sw_sync +%0d: got %h want %h", i + 1, bus_if.DIN, want[i]);
      end
    end
  endtask

  task automatic test_reset_write();
    logic [15:0] e; bit k;
    step(16'h1006, 16'hA5A5, 1'b1, 1'b0, e, k);
    step(16'h2000, 16'h0155, 1'b1, 1'b0, e, k);
    step(16'h1006, 16'h5555, 1'b1, 1'b1, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'h0000) begin
      n_fail++; $display("FAIL rstw_din: got %h want 0000", bus_if.DIN);
    end
    n_checks++;
    if (LEDR !== 10'h000) begin
      n_fail++; $display("FAIL rstw_ledr: got %h want 000", LEDR);
    end
    step(16'h1006, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'hA5A5) begin
      n_fail++; $display("FAIL rstw_ram_kept: got %h want a5a5", bus_if.DIN);
    end
  endtask

  task automatic test_region4();
    logic [15:0] e; bit k;
    logic [15:0] wr_want, rej_want;
    step(16'h0000, 16'h0, 1'b0, 1'b1, e, k);
    for (int i = 0; i < 3; i++) step(16'(16'h1020 + i), 16'(i), 1'b1, 1'b0, e, k);
    for (int i = 0; i < 2; i++) step(16'(16'h0002 + i), 16'hFFFF, 1'b1, 1'b0, e, k);
    wr_want  = CNT_EN ? 16'd3 : 16'd0;
    rej_want = CNT_EN ? 16'd2 : 16'd0;
    step(16'h4000, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== wr_want || e !== wr_want) begin
      n_fail++; $display("FAIL cnt_wr: got %h want %h", bus_if.DIN, wr_want);
    end
    step(16'h4001, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== rej_want || e !== rej_want) begin
      n_fail++; $display("FAIL cnt_rej: got %h want %h", bus_if.DIN, rej_want);
    end
    step(16'h4000, 16'h0, 1'b1, 1'b0, e, k);
    step(16'h4000, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'h0000) begin
      n_fail++; $display("FAIL cnt_clear_wr: got %h want 0000", bus_if.DIN);
    end
    step(16'h4001, 16'h0, 1'b0, 1'b0, e, k);
    n_checks++;
    if (bus_if.DIN !== 16'h0000) begin
      n_fail++; $display("FAIL cnt_clear_rej: got %h want 0000", bus_if.DIN);
    end
  endtask

  task automatic test_random();
    logic [15:0] e, addr; bit k;
    logic [3:0] nibs [6] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9};
    logic [3:0] nib;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) SW = 10'($urandom);
      nib  = nibs[$urandom_range(0, 5)];
      addr = {nib, 12'($urandom)};
      if (nib == 4'h4) addr = 16'(16'h4000 + $urandom_range(0, 2));
      step(addr, 16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 80) == 0), e, k);
      if (k) begin
        n_checks++;
        if (bus_if.DIN !== e) begin
          n_fail++; $display("FAIL rand_din i=%0d addr=%h: got %h want %h", i, addr, bus_if.DIN, e);
        end
      end
      n_checks++;
      if (LEDR !== m_led) begin
        n_fail++; $display("FAIL rand_ledr i=%0d: got %h want %h", i, LEDR, m_led);
      end
    end
  endtask

  initial begin
    Reset       = 1'b1;
    SW          = 10'h000;
    bus_if.ADDR = 16'h0000;
    bus_if.DOUT = 16'h0000;
    bus_if.W    = 1'b0;
    for (int i = 0; i < 128; i++) m_ram_v[i] = 1'b0;
    m_led = '0; m_meta = '0; m_sync = '0; m_wr = '0; m_rej = '0;
    @(negedge Clock);
    test_reset();
    test_rom();
    test_ram();
    test_led();
    test_sw();
    test_reset_write();
    test_region4();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
